// File: rtl/bsg_vc_link_injector_if.sv
// Client-side per-VC streams and the VC link toward a router input port.
// Signal names follow the injector's pin names so the link can be traced end to end.
interface bsg_vc_link_injector_if #(
    parameter int flit_width_p = 16,
    parameter int vc_num_p     = 2
);
    logic [vc_num_p-1:0]              client_v_i;
    logic [vc_num_p*flit_width_p-1:0] client_data_i;
    logic [vc_num_p-1:0]              client_ready_o;
    logic [flit_width_p-1:0]          link_data_o;
    logic [vc_num_p-1:0]              link_v_o;
    logic [vc_num_p-1:0]              link_ready_and_i;

    // Handshakes: a client flit moves when client_v_i[j] & client_ready_o[j];
    // a link flit moves when link_v_o[j] & link_ready_and_i[j]. Ready never
    // depends on valid; link_v_o may depend combinationally on link_ready_and_i.
    modport master (
        output client_v_i,
        output client_data_i,
        output link_ready_and_i,
        input  client_ready_o,
        input  link_data_o,
        input  link_v_o
    );

    modport slave (
        input  client_v_i,
        input  client_data_i,
        input  link_ready_and_i,
        output client_ready_o,
        output link_data_o,
        output link_v_o
    );
endinterface

// File: rtl/bsg_vc_link_injector.sv
// Per-VC 2-entry FIFOs multiplexed onto one VC link by a round-robin arbiter.
// Define BSG_VC_INJECT_PKT_LOCK_EN to hold the grant on one VC for a whole packet.
module bsg_vc_link_injector #(
    parameter int flit_width_p = 16,  // no meaningful default; set per instance
    parameter int vc_num_p     = 2,
    parameter int cord_width_p = 6,
    parameter int len_width_p  = 4    // no meaningful default; set per instance
) (
    input logic                   clk_i,
    input logic                   reset_n_i,
    bsg_vc_link_injector_if.slave link_if
);
    localparam int vc_id_width_lp = (vc_num_p > 1) ? $clog2(vc_num_p) : 1;

    if (cord_width_p + len_width_p > flit_width_p) begin : g_len_field_check
        $error("header length field does not fit inside the flit");
    end

    logic [flit_width_p-1:0]   mem_q [vc_num_p][2];
    logic [flit_width_p-1:0]   mem_d [vc_num_p][2];
    logic [1:0]                count_q [vc_num_p];
    logic [1:0]                count_d [vc_num_p];
    logic [vc_num_p-1:0]       wr_ptr_q, wr_ptr_d;
    logic [vc_num_p-1:0]       rd_ptr_q, rd_ptr_d;
    logic [vc_num_p-1:0]       ready_q, ready_d;
    logic [vc_id_width_lp-1:0] ptr_q, ptr_d;

    logic [vc_num_p-1:0]       enq, deq, eligible, lock_mask, link_v;
    logic                      any_v;
    logic [vc_id_width_lp-1:0] grant;
    logic [flit_width_p-1:0]   link_data;

`ifdef BSG_VC_INJECT_PKT_LOCK_EN
    logic                      locked_q, locked_d;
    logic [vc_id_width_lp-1:0] lock_vc_q, lock_vc_d;
    logic [len_width_p-1:0]    lock_cnt_q, lock_cnt_d;
    logic [len_width_p-1:0]    hdr_len;

    always_comb begin
        lock_mask = '1;
        if (locked_q) begin
            lock_mask = '0;
            lock_mask[lock_vc_q] = 1'b1;
        end
    end

    // Any flit granted while unlocked is a packet header.
    always_comb begin
        locked_d   = locked_q;
        lock_vc_d  = lock_vc_q;
        lock_cnt_d = lock_cnt_q;
        hdr_len    = link_data[cord_width_p +: len_width_p];
        if (any_v) begin
            if (locked_q) begin
                lock_cnt_d = lock_cnt_q - 1'b1;
                if (lock_cnt_q == len_width_p'(1)) begin
                    locked_d = 1'b0;
                end
            end else if (hdr_len != '0) begin
                locked_d   = 1'b1;
                lock_vc_d  = grant;
                lock_cnt_d = hdr_len;
            end
        end
    end
`else
    always_comb begin
        lock_mask = '1;
    end
`endif

    always_comb begin
        eligible = '0;
        for (int j = 0; j < vc_num_p; j++) begin
            eligible[j] = (count_q[j] != 2'd0) & link_if.link_ready_and_i[j] & lock_mask[j];
        end
    end

    // First eligible VC at or after ptr_q, wrapping around.
    always_comb begin
        int idx;
        idx   = 0;
        any_v = 1'b0;
        grant = '0;
        for (int i = 0; i < vc_num_p; i++) begin
            idx = (int'(ptr_q) + i) % vc_num_p;
            if (!any_v && eligible[idx]) begin
                any_v = 1'b1;
                grant = vc_id_width_lp'(idx);
            end
        end
        link_v    = '0;
        link_data = '0;
        if (any_v) begin
            link_v[grant] = 1'b1;
            link_data     = mem_q[grant][rd_ptr_q[grant]];
        end
        ptr_d = ptr_q;
        if (any_v) begin
            ptr_d = vc_id_width_lp'((int'(grant) + 1) % vc_num_p);
        end
    end

    always_comb begin
        mem_d    = mem_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ready_d  = ready_q;
        enq      = '0;
        deq      = '0;
        for (int j = 0; j < vc_num_p; j++) begin
            enq[j] = link_if.client_v_i[j] & ready_q[j];
            deq[j] = link_v[j];
            if (enq[j]) begin
                mem_d[j][wr_ptr_q[j]] = link_if.client_data_i[j*flit_width_p +: flit_width_p];
                wr_ptr_d[j] = ~wr_ptr_q[j];
            end
            if (deq[j]) begin
                rd_ptr_d[j] = ~rd_ptr_q[j];
            end
            case ({enq[j], deq[j]})
                2'b10:   count_d[j] = count_q[j] + 2'd1;
                2'b01:   count_d[j] = count_q[j] - 2'd1;
                default: count_d[j] = count_q[j];
            endcase
            // Registered ready: reflects occupancy after this cycle's moves.
            ready_d[j] = (count_d[j] != 2'd2);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int j = 0; j < vc_num_p; j++) begin
                mem_q[j][0] <= '0;
                mem_q[j][1] <= '0;
                count_q[j]  <= 2'd0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= '0;
            ptr_q    <= '0;
        end else begin
            for (int j = 0; j < vc_num_p; j++) begin
                mem_q[j][0] <= mem_d[j][0];
                mem_q[j][1] <= mem_d[j][1];
                count_q[j]  <= count_d[j];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= ready_d;
            ptr_q    <= ptr_d;
        end
    end

`ifdef BSG_VC_INJECT_PKT_LOCK_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            locked_q   <= 1'b0;
            lock_vc_q  <= '0;
            lock_cnt_q <= '0;
        end else begin
            locked_q   <= locked_d;
            lock_vc_q  <= lock_vc_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end
`endif

    assign link_if.client_ready_o = ready_q;
    assign link_if.link_v_o       = link_v;
    assign link_if.link_data_o    = link_data;
endmodule
